// File: rtl/adc_frame_sync_if.sv
// Deserializer-to-FIFO word bus seen by the frame-sync controller.
// master: stream source / FIFO side; slave: the controller.
interface adc_frame_sync_if #(
    parameter int unsigned W = 16
);
    logic         word_valid;
    logic [W-1:0] word_in;
    logic         fco;
    logic         fifo_full;
    logic         wr_en;
    logic [W-1:0] word_out;
    logic         frame_start;

    modport master (
        output word_valid, word_in, fco, fifo_full,
        input  wr_en, word_out, frame_start
    );

    modport slave (
        input  word_valid, word_in, fco, fifo_full,
        output wr_en, word_out, frame_start
    );
endinterface

// File: rtl/adc_frame_sync_ctrl.sv
// FCO frame-alignment controller: flywheel lock on the frame marker and
// forwarding of aligned, non-overflowing words to the CDC FIFO.
module adc_frame_sync_ctrl #(
    parameter int unsigned W        = 16,
    parameter int unsigned PERIOD   = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      dco_clk,
    input  logic                      rst_n,
    input  logic                      enable,
    adc_frame_sync_if.slave           bus,
    output logic                      aligned,
    output logic [$clog2(PERIOD)-1:0] phase,
    output logic [1:0]                state_o,
    output logic [CNT_W-1:0]          lock_loss_cnt,
    output logic [CNT_W-1:0]          overflow_cnt
);
    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [GW-1:0]  good_q, good_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic           aligned_q, aligned_d;
    logic           wr_en_q, wr_en_d;
    logic           fs_q, fs_d;
    logic [W-1:0]   word_q, word_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic [PW-1:0]  pos_cur_c;
    logic           boundary_c;
    logic [GW-1:0]  good_inc_c;
    logic [MW-1:0]  miss_inc_c;
    logic           writable_c;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            aligned_q <= 1'b0;
            wr_en_q   <= 1'b0;
            fs_q      <= 1'b0;
            word_q    <= '0;
            loss_q    <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            aligned_q <= aligned_d;
            wr_en_q   <= wr_en_d;
            fs_q      <= fs_d;
            word_q    <= word_d;
            loss_q    <= loss_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_d     = good_q;
        miss_d     = miss_q;
        aligned_d  = aligned_q;
        wr_en_d    = 1'b0;
        fs_d       = 1'b0;
        word_d     = word_q;
        loss_d     = loss_q;
        ovf_d      = ovf_q;
        writable_c = 1'b0;

        pos_cur_c  = (pos_q == PW'(PERIOD - 1)) ? '0 : pos_q + PW'(1);
        boundary_c = (pos_cur_c == '0);
        good_inc_c = good_q + GW'(1);
        miss_inc_c = miss_q + MW'(1);

        if (!enable) begin
            state_d   = ST_IDLE;
            aligned_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_SEARCH;
                ST_SEARCH: begin
                    if (bus.word_valid) begin
                        if (bus.fco) begin
                            pos_d   = '0;
                            good_d  = '0;
                            state_d = ST_VERIFY;
                        end else begin
                            pos_d = pos_cur_c;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (bus.word_valid) begin
                        pos_d = pos_cur_c;
                        if (boundary_c && bus.fco) begin
                            good_d = good_inc_c;
                            if (good_inc_c == GW'(LOCK_CNT)) begin
                                state_d    = ST_LOCKED;
                                aligned_d  = 1'b1;
                                miss_d     = '0;
                                writable_c = 1'b1;
                            end
                        end else if (bus.fco) begin
                            pos_d  = '0;
                            good_d = '0;
                        end else if (boundary_c) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: position never re-anchors while locked
                    if (bus.word_valid) begin
                        pos_d = pos_cur_c;
                        if (bus.fco != boundary_c) begin
                            miss_d = miss_inc_c;
                            if (miss_inc_c == MW'(LOSS_CNT)) begin
                                state_d   = ST_SEARCH;
                                aligned_d = 1'b0;
                                miss_d    = '0;
                                loss_d    = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                            end else begin
                                writable_c = 1'b1;
                            end
                        end else begin
                            if (boundary_c) miss_d = '0;
                            writable_c = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Full FIFO drops the word outright; the source cannot be stalled
        if (writable_c) begin
            if (!bus.fifo_full) begin
                wr_en_d = 1'b1;
                word_d  = bus.word_in;
                fs_d    = boundary_c;
            end else begin
                ovf_d = (ovf_q == '1) ? ovf_q : ovf_q + CNT_W'(1);
            end
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.word_out    = word_q;
    assign bus.frame_start = fs_q;
    assign aligned         = aligned_q;
    assign phase           = pos_q;
    assign state_o         = state_q;
    assign lock_loss_cnt   = loss_q;
    assign overflow_cnt    = ovf_q;
endmodule

// File: tb/tb_adc_frame_sync_ctrl.sv
// Directed bench for adc_frame_sync_ctrl: lock, flywheel, loss, re-anchor,
// overflow, enable and asynchronous reset scenarios.
module tb_adc_frame_sync_ctrl;
    localparam int unsigned W      = 16;
    localparam int unsigned PERIOD = 16;
    localparam int unsigned CNT_W  = 16;

    logic                      dco_clk = 1'b0;
    logic                      rst_n;
    logic                      enable;
    logic                      aligned;
    logic [$clog2(PERIOD)-1:0] phase;
    logic [1:0]                state_o;
    logic [CNT_W-1:0]          lock_loss_cnt;
    logic [CNT_W-1:0]          overflow_cnt;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] seq;

    always #5 dco_clk = ~dco_clk;

    adc_frame_sync_if #(.W(W)) bus ();

    adc_frame_sync_ctrl #(
        .W(W), .PERIOD(PERIOD), .LOCK_CNT(4), .LOSS_CNT(2), .CNT_W(CNT_W)
    ) dut (
        .dco_clk       (dco_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .bus           (bus),
        .aligned       (aligned),
        .phase         (phase),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt),
        .overflow_cnt  (overflow_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One valid word; checks the registered write result one edge later
    task automatic send_word(input logic f, input logic full, input logic exp_wr, input logic exp_fs);
        @(negedge dco_clk);
        bus.word_valid = 1'b1;
        bus.word_in    = seq;
        bus.fco        = f;
        bus.fifo_full  = full;
        @(posedge dco_clk);
        #1;
        check_eq("wr_en", 32'(bus.wr_en), 32'(exp_wr));
        check_eq("frame_start", 32'(bus.frame_start), 32'(exp_wr & exp_fs));
        if (exp_wr) check_eq("word_out", 32'(bus.word_out), 32'(seq));
        seq = seq + W'(1);
    endtask

    // 15 unmarked words then the boundary word carrying fco=mark
    task automatic run_frame(input logic mark, input logic exp_body, input logic exp_bnd);
        for (int i = 0; i < 15; i++) send_word(1'b0, 1'b0, exp_body, 1'b0);
        send_word(mark, 1'b0, exp_bnd, 1'b1);
    endtask

    task automatic idle_cycle();
        @(negedge dco_clk);
        bus.word_valid = 1'b0;
        bus.fco        = 1'b0;
        @(posedge dco_clk);
        #1;
        check_eq("idle_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("idle_fs", 32'(bus.frame_start), 32'd0);
    endtask

    task automatic lock_from_search();
        send_word(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("anchor_state", 32'(state_o), 32'd2);
        check_eq("anchor_phase", 32'(phase), 32'd0);
        repeat (3) run_frame(1'b1, 1'b0, 1'b0);
        check_eq("verify_state", 32'(state_o), 32'd2);
        check_eq("verify_aligned", 32'(aligned), 32'd0);
        run_frame(1'b1, 1'b0, 1'b1);
        check_eq("lock_state", 32'(state_o), 32'd3);
        check_eq("lock_aligned", 32'(aligned), 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        bus.fco        = 1'b0;
        bus.fifo_full  = 1'b0;
        seq            = 16'h1000;

        repeat (3) @(posedge dco_clk);
        #1;
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_aligned", 32'(aligned), 32'd0);
        check_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("rst_loss", 32'(lock_loss_cnt), 32'd0);
        check_eq("rst_ovf", 32'(overflow_cnt), 32'd0);

        @(negedge dco_clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge dco_clk);
        #1;
        check_eq("idle_to_search", 32'(state_o), 32'd1);
        repeat (3) send_word(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("search_hold", 32'(state_o), 32'd1);

        // Clean stream lock and steady writes
        lock_from_search();
        repeat (2) run_frame(1'b1, 1'b1, 1'b1);
        idle_cycle();
        check_eq("idle_phase_hold", 32'(phase), 32'd0);

        // Single missing marker is ridden through
        run_frame(1'b0, 1'b1, 1'b1);
        check_eq("miss1_aligned", 32'(aligned), 32'd1);
        check_eq("miss1_loss", 32'(lock_loss_cnt), 32'd0);
        run_frame(1'b1, 1'b1, 1'b1);

        // Two consecutive misses drop lock; second miss word not written
        run_frame(1'b0, 1'b1, 1'b1);
        run_frame(1'b0, 1'b1, 1'b0);
        check_eq("miss2_aligned", 32'(aligned), 32'd0);
        check_eq("miss2_state", 32'(state_o), 32'd1);
        check_eq("miss2_loss", 32'(lock_loss_cnt), 32'd1);
        lock_from_search();

        // Lose lock again, then spurious marker in VERIFY after 2 good frames
        run_frame(1'b0, 1'b1, 1'b1);
        run_frame(1'b0, 1'b1, 1'b0);
        check_eq("loss2_cnt", 32'(lock_loss_cnt), 32'd2);
        send_word(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) run_frame(1'b1, 1'b0, 1'b0);
        repeat (6) send_word(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("reanchor_state", 32'(state_o), 32'd2);
        check_eq("reanchor_phase", 32'(phase), 32'd0);
        repeat (3) run_frame(1'b1, 1'b0, 1'b0);
        check_eq("no_early_lock", 32'(state_o), 32'd2);
        run_frame(1'b1, 1'b0, 1'b1);
        check_eq("relock_state", 32'(state_o), 32'd3);

        // FIFO full for three words while locked
        for (int i = 0; i < 15; i++) begin
            logic full;
            full = (i >= 4) && (i < 7);
            send_word(1'b0, full, !full, 1'b0);
        end
        send_word(1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("ovf_cnt", 32'(overflow_cnt), 32'd3);
        check_eq("ovf_aligned", 32'(aligned), 32'd1);

        // enable low while locked
        @(negedge dco_clk);
        enable         = 1'b0;
        bus.word_valid = 1'b0;
        @(posedge dco_clk);
        #1;
        check_eq("dis_state", 32'(state_o), 32'd0);
        check_eq("dis_aligned", 32'(aligned), 32'd0);
        check_eq("dis_loss_hold", 32'(lock_loss_cnt), 32'd2);
        check_eq("dis_ovf_hold", 32'(overflow_cnt), 32'd3);
        @(negedge dco_clk);
        enable = 1'b1;
        @(posedge dco_clk);
        #1;
        check_eq("reen_state", 32'(state_o), 32'd1);
        lock_from_search();
        repeat (5) send_word(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pre_rst_phase", 32'(phase), 32'd5);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("arst_word_out", 32'(bus.word_out), 32'd0);
        check_eq("arst_fs", 32'(bus.frame_start), 32'd0);
        check_eq("arst_aligned", 32'(aligned), 32'd0);
        check_eq("arst_phase", 32'(phase), 32'd0);
        check_eq("arst_state", 32'(state_o), 32'd0);
        check_eq("arst_loss", 32'(lock_loss_cnt), 32'd0);
        check_eq("arst_ovf", 32'(overflow_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_frame_sync_ctrl.md
Name: adc_frame_sync_ctrl

Overview:
- Frame-alignment controller in the dco_clk domain of the ADC LVDS front-end. Sits between the DDR deserializer (16-bit words plus word_valid) and the CDC FIFO write port.
- Locks onto the FCO frame marker with a flywheel position counter and qualifies lock over several frames. Declares loss of lock after consecutive misses.
- Gates FIFO writes: only aligned, non-overflowing words are forwarded, tagged with a frame-start flag.

Parameters:
- W, 16, data word width
- PERIOD, 16, words per FCO frame (≥2)
- LOCK_CNT, 4, consecutive good frame boundaries required after anchor to declare lock (≥1)
- LOSS_CNT, 2, consecutive bad frame boundaries in LOCKED that drop lock (≥1)
- CNT_W, 16, width of the saturating statistics counters

Ports:
- dco_clk  in  1  word clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sync enable; low forces IDLE
- word_valid  in  1  deserializer word strobe
- word_in  in  W  deserialized word
- fco  in  1  frame marker; sampled only when word_valid=1
- fifo_full  in  1  FIFO write-side full
- wr_en  out  1  registered FIFO write strobe
- word_out  out  W  registered data, valid with wr_en
- frame_start  out  1  registered; high with wr_en for a position-0 word
- aligned  out  1  registered lock flag
- phase  out  $clog2(PERIOD)  position of the last accepted word
- state_o  out  2  IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3
- lock_loss_cnt  out  CNT_W  saturating count of LOCKED→SEARCH transitions
- overflow_cnt  out  CNT_W  saturating count of words dropped due to fifo_full

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is dco_clk. Reset gives state=IDLE and zeroes all outputs and all counters.
- IDLE: enable=1 moves to SEARCH on the next edge.
- enable=0 in any state moves to IDLE on the next edge and clears aligned. Statistics counters hold their values.
- Events are evaluated only on cycles with word_valid=1. Cycles without word_valid hold all state and deassert wr_en and frame_start.
- Position counter pos (register exposed as phase):
  - pos_cur = (pos==PERIOD-1) ? 0 : pos+1.
  - Each word_valid cycle loads pos_cur into pos, except where an anchor says otherwise.
  - A boundary is a word with pos_cur==0.
  - good = (fco==1) at a boundary.
  - bad = fco differs from (pos_cur==0): a missing marker at a boundary, or a marker off a boundary.
- SEARCH:
  - word_valid && fco: anchor (pos=0, good_cnt=0) and go to VERIFY.
  - Otherwise stay. pos free-runs and nothing is written.
- VERIFY:
  - good: good_cnt+1; when it reaches LOCK_CNT, go to LOCKED and assert aligned.
  - fco off a boundary: re-anchor (pos=0, good_cnt=0), stay in VERIFY.
  - Missing fco at a boundary: go to SEARCH.
- LOCKED:
  - pos is a flywheel and is never re-anchored.
  - bad: miss_cnt+1. If it reaches LOSS_CNT: go to SEARCH, clear aligned, increment lock_loss_cnt.
  - good: miss_cnt=0.
  - Non-boundary words with no fco leave miss_cnt unchanged.
- Write qualification. A word is writable if word_valid=1 and one of:
  - state is LOCKED and this word does not cause lock loss;
  - state is VERIFY and this word completes the lock (the locking boundary word is written).
- Writable word with fifo_full=0, registered on the next edge:
  - wr_en=1
  - word_out=word_in
  - frame_start=(pos_cur==0)
  - Latency is 1 cycle.
- Writable word with fifo_full=1: wr_en=0 and overflow_cnt+1. The word is dropped; there is no retry.
- Saturating counters stop at 2^CNT_W-1.
- aligned and state_o update on the same edge as the transition.

Test Plan:
- Clean stream, fco every 16 words, enable=1:
  - First fco anchors; aligned=1 one cycle after the 4th subsequent marker word.
  - That word is written with frame_start=1.
  - Afterwards frame_start recurs every 16 writes; word_out equals the input sequence delayed 1 cycle.
- LOCKED, one marker omitted:
  - aligned stays 1 and lock_loss_cnt=0.
  - Writes continue uninterrupted, and frame_start still pulses at the flywheel boundary.
- LOCKED, two consecutive markers omitted:
  - aligned drops after the 2nd missing boundary word, which is not written.
  - state_o=1 and lock_loss_cnt=1.
  - Relock takes 1 anchor plus 4 good frames.
- VERIFY after 2 good frames, spurious fco at pos 7:
  - Re-anchor with good_cnt=0.
  - Lock requires 4 further good frames measured from the new anchor.
- LOCKED, fifo_full=1 for 3 word_valid cycles:
  - wr_en=0 on those 3 words; overflow_cnt=3; aligned stays 1.
- Reset and enable:
  - rst_n=0 asserted mid-LOCKED, between clock edges: all outputs are 0 immediately.
  - Separately, enable=0 while LOCKED: IDLE next edge, aligned=0, counters retained.
